// File: rtl/mips_pkg.sv
// Shared constants and state type for the MIPS core.
// Build option: MIPS_SEQ_PERF_CNT_EN adds a retired-instruction counter.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDR    = 32'h00000000;

  typedef enum logic [1:0] {
    RUN,
    MD_WAIT,
    HALTED
  } seq_state_t;

endpackage

// File: rtl/mips_next_pc.sv
// Combinational branch / J / JR target computation.
// Shared with the later pipelined core.
module mips_next_pc (
  input  logic [31:0] pc_i,
  input  logic        br_i,
  input  logic [15:0] off_i,
  input  logic        j_i,
  input  logic [25:0] idx_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] pc4_o,
  output logic        xfer_o,
  output logic [31:0] target_o
);

  logic [31:0] br_off;

  assign pc4_o  = pc_i + 32'd4;
  assign br_off = {{14{off_i[15]}}, off_i, 2'b00};

  always_comb begin
    xfer_o   = 1'b0;
    target_o = pc4_o;
    unique case (1'b1)
      br_i: begin
        xfer_o   = 1'b1;
        target_o = pc4_o + br_off;
      end
      j_i: begin
        xfer_o   = 1'b1;
        target_o = {pc4_o[31:28], idx_i, 2'b00};
      end
      jr_i: begin
        xfer_o   = 1'b1;
        target_o = jr_target_i & 32'hFFFF_FFFC;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_pc_sequencer.sv
// PC, delay slot, mult/div wait and halt sequencing with gated strobes.
// Build option: MIPS_SEQ_PERF_CNT_EN adds output retired_count.
module mips_pc_sequencer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        dec_branch_taken,
  input  logic [15:0] dec_branch_offset,
  input  logic        dec_jump,
  input  logic [25:0] dec_jump_index,
  input  logic        dec_jump_reg,
  input  logic [31:0] dec_jr_target,
  input  logic        dec_reg_write,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_muldiv,
  input  logic        muldiv_done,
  output logic [31:0] instr_address,
  output logic        active,
  output logic [31:0] link_value,
  output logic        reg_write_en,
  output logic        data_read,
  output logic        data_write,
  output logic        muldiv_start,
`ifdef MIPS_SEQ_PERF_CNT_EN
  output logic [31:0] retired_count,
`endif
  output logic        in_delay_slot
);

  seq_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] link_q, link_d;
  logic        pend_q, pend_d;
  logic        act_q, act_d;
  logic        adv;
  logic        run_en;
  logic [31:0] pc4;
  logic [31:0] xfer_tgt;
  logic        xfer;

  mips_next_pc u_next_pc (
    .pc_i        (pc_q),
    .br_i        (dec_branch_taken),
    .off_i       (dec_branch_offset),
    .j_i         (dec_jump),
    .idx_i       (dec_jump_index),
    .jr_i        (dec_jump_reg),
    .jr_target_i (dec_jr_target),
    .pc4_o       (pc4),
    .xfer_o      (xfer),
    .target_o    (xfer_tgt)
  );

  assign run_en       = clk_enable & (state_q == RUN);
  assign reg_write_en = run_en & dec_reg_write;
  assign data_read    = run_en & dec_load;
  assign data_write   = run_en & dec_store;
  assign muldiv_start = run_en & dec_muldiv;

  assign instr_address = pc_q;
  assign active        = act_q;
  assign link_value    = link_q;
  assign in_delay_slot = pend_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    pend_d  = pend_q;
    adv     = 1'b0;
    if (clk_enable) begin
      unique case (state_q)
        RUN: begin
          if (dec_muldiv) state_d = MD_WAIT;
          else            adv     = 1'b1;
        end
        MD_WAIT: adv = muldiv_done;
        HALTED:  ;
        default: state_d = RUN;
      endcase
    end
    if (adv) begin
      state_d = RUN;
      // A delay slot never starts a new transfer of its own.
      if (pend_q) begin
        pend_d = 1'b0;
        pc_d   = tgt_q;
        if (tgt_q == HALT_ADDR) state_d = HALTED;
      end else begin
        pc_d = pc4;
        if (xfer && state_q == RUN) begin
          pend_d = 1'b1;
          tgt_d  = xfer_tgt;
        end
      end
    end
    link_d = pc_d + 32'd8;
    act_d  = (state_d != HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      tgt_q   <= '0;
      pend_q  <= 1'b0;
      link_q  <= RESET_VECTOR + 32'd8;
      act_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      link_q  <= link_d;
      act_q   <= act_d;
    end
  end

`ifdef MIPS_SEQ_PERF_CNT_EN
  logic [31:0] rc_q;

  always_ff @(posedge clk) begin
    if (reset)    rc_q <= '0;
    else if (adv) rc_q <= rc_q + 32'd1;
  end

  assign retired_count = rc_q;
`endif

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Scoreboard bench for mips_pc_sequencer with directed vectors.
// Build option: MIPS_SEQ_PERF_CNT_EN enables retired_count checks.
module tb_mips_pc_sequencer;

  typedef struct {
    bit          en;
    bit          rst;
    bit          bt;
    bit   [15:0] off;
    bit          j;
    bit   [25:0] idx;
    bit          jr;
    bit   [31:0] jrt;
    bit          rw;
    bit          ld;
    bit          st;
    bit          md;
    bit          done;
  } din_t;

  typedef struct {
    bit   [31:0] pc;
    bit          act;
    bit          ids;
    bit          rwe;
    bit          rd;
    bit          wr;
    bit          mds;
    bit   [31:0] link;
    bit          chk_rc;
    bit   [31:0] rc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        dec_branch_taken = 1'b0;
  logic [15:0] dec_branch_offset = '0;
  logic        dec_jump = 1'b0;
  logic [25:0] dec_jump_index = '0;
  logic        dec_jump_reg = 1'b0;
  logic [31:0] dec_jr_target = '0;
  logic        dec_reg_write = 1'b0;
  logic        dec_load = 1'b0;
  logic        dec_store = 1'b0;
  logic        dec_muldiv = 1'b0;
  logic        muldiv_done = 1'b0;
  logic [31:0] instr_address;
  logic        active;
  logic [31:0] link_value;
  logic        reg_write_en;
  logic        data_read;
  logic        data_write;
  logic        muldiv_start;
  logic        in_delay_slot;
  logic [31:0] rc_w;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mips_pc_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .clk_enable        (clk_enable),
    .dec_branch_taken  (dec_branch_taken),
    .dec_branch_offset (dec_branch_offset),
    .dec_jump          (dec_jump),
    .dec_jump_index    (dec_jump_index),
    .dec_jump_reg      (dec_jump_reg),
    .dec_jr_target     (dec_jr_target),
    .dec_reg_write     (dec_reg_write),
    .dec_load          (dec_load),
    .dec_store         (dec_store),
    .dec_muldiv        (dec_muldiv),
    .muldiv_done       (muldiv_done),
    .instr_address     (instr_address),
    .active            (active),
    .link_value        (link_value),
    .reg_write_en      (reg_write_en),
    .data_read         (data_read),
    .data_write        (data_write),
    .muldiv_start      (muldiv_start),
`ifdef MIPS_SEQ_PERF_CNT_EN
    .retired_count     (rc_w),
`endif
    .in_delay_slot     (in_delay_slot)
  );

`ifndef MIPS_SEQ_PERF_CNT_EN
  assign rc_w = '0;
`endif

  function automatic din_t nop();
    din_t d;
    d = '{default: '0};
    d.en = 1'b1;
    return d;
  endfunction

  function automatic exp_t E(bit [31:0] pc, bit act, bit ids,
                             bit rwe, bit rd, bit wr, bit mds);
    exp_t e;
    e.pc = pc; e.act = act; e.ids = ids;
    e.rwe = rwe; e.rd = rd; e.wr = wr; e.mds = mds;
    e.link = pc + 32'd8;
    e.chk_rc = 1'b0; e.rc = '0;
    return e;
  endfunction

  function automatic exp_t R(exp_t e, bit [31:0] rc);
    exp_t r;
    r = e;
    r.chk_rc = 1'b1;
    r.rc = rc;
    return r;
  endfunction

  task automatic cyc(input din_t d, input exp_t e);
    @(posedge clk);
    #1;
    clk_enable        = d.en;
    reset             = d.rst;
    dec_branch_taken  = d.bt;
    dec_branch_offset = d.off;
    dec_jump          = d.j;
    dec_jump_index    = d.idx;
    dec_jump_reg      = d.jr;
    dec_jr_target     = d.jrt;
    dec_reg_write     = d.rw;
    dec_load          = d.ld;
    dec_store         = d.st;
    dec_muldiv        = d.md;
    muldiv_done       = d.done;
    sb.push_back(e);
  endtask

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, a, x, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", instr_address, e.pc);
        chk("active", {31'b0, active}, {31'b0, e.act});
        chk("ids", {31'b0, in_delay_slot}, {31'b0, e.ids});
        chk("rwe", {31'b0, reg_write_en}, {31'b0, e.rwe});
        chk("rd", {31'b0, data_read}, {31'b0, e.rd});
        chk("wr", {31'b0, data_write}, {31'b0, e.wr});
        chk("mds", {31'b0, muldiv_start}, {31'b0, e.mds});
        chk("link", link_value, e.link);
`ifdef MIPS_SEQ_PERF_CNT_EN
        if (e.chk_rc) chk("rc", rc_w, e.rc);
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    din_t d;
    @(posedge clk);
    // Three plain instructions after reset
    d = nop(); d.rw = 1;
    cyc(d, R(E(32'hBFC00000, 1, 0, 1, 0, 0, 0), 0));
    d = nop(); d.ld = 1;
    cyc(d, E(32'hBFC00004, 1, 0, 0, 1, 0, 0));
    d = nop(); d.st = 1;
    cyc(d, E(32'hBFC00008, 1, 0, 0, 0, 1, 0));
    d = nop();
    cyc(d, E(32'hBFC0000C, 1, 0, 0, 0, 0, 0));
    // Backward branch, target BFC0000C
    d = nop(); d.bt = 1; d.off = 16'hFFFE;
    cyc(d, E(32'hBFC00010, 1, 0, 0, 0, 0, 0));
    d = nop(); d.rw = 1;
    cyc(d, E(32'hBFC00014, 1, 1, 1, 0, 0, 0));
    d = nop();
    cyc(d, E(32'hBFC0000C, 1, 0, 0, 0, 0, 0));
    cyc(d, E(32'hBFC00010, 1, 0, 0, 0, 0, 0));
    // JAL to BFC00020, link BFC0001C
    d = nop(); d.j = 1; d.idx = 26'h3F00008; d.rw = 1;
    cyc(d, E(32'hBFC00014, 1, 0, 1, 0, 0, 0));
    // Branch in delay slot is ignored
    d = nop(); d.bt = 1; d.off = 16'h0100;
    cyc(d, E(32'hBFC00018, 1, 1, 0, 0, 0, 0));
    // MULT, done 5 cycles after start
    d = nop(); d.md = 1;
    cyc(d, E(32'hBFC00020, 1, 0, 0, 0, 0, 1));
    d = nop(); d.md = 1; d.rw = 1; d.ld = 1;
    for (int i = 0; i < 4; i++)
      cyc(d, E(32'hBFC00020, 1, 0, 0, 0, 0, 0));
    d.done = 1;
    cyc(d, E(32'hBFC00020, 1, 0, 0, 0, 0, 0));
    // JR to BFC00043 -> BFC00040, stall in delay slot
    d = nop(); d.jr = 1; d.jrt = 32'hBFC00043;
    cyc(d, E(32'hBFC00024, 1, 0, 0, 0, 0, 0));
    d = nop(); d.en = 0; d.rw = 1; d.st = 1; d.done = 1;
    for (int i = 0; i < 4; i++)
      cyc(d, E(32'hBFC00028, 1, 1, 0, 0, 0, 0));
    d = nop(); d.rw = 1;
    cyc(d, E(32'hBFC00028, 1, 1, 1, 0, 0, 0));
    // JALR to 0, delay slot writes, then halt
    d = nop(); d.jr = 1; d.jrt = 32'h0; d.rw = 1;
    cyc(d, E(32'hBFC00040, 1, 0, 1, 0, 0, 0));
    d = nop(); d.rw = 1;
    cyc(d, E(32'hBFC00044, 1, 1, 1, 0, 0, 0));
    d = nop(); d.rw = 1; d.ld = 1; d.st = 1;
    d.md = 1; d.bt = 1; d.off = 16'h0004;
    for (int i = 0; i < 10; i++)
      cyc(d, E(32'h00000000, 0, 0, 0, 0, 0, 0));
    // Reset out of HALTED
    d = nop(); d.rst = 1;
    cyc(d, E(32'h00000000, 0, 0, 0, 0, 0, 0));
    d = nop(); d.md = 1;
    cyc(d, R(E(32'hBFC00000, 1, 0, 0, 0, 0, 1), 0));
    // Reset in MD_WAIT
    d = nop(); d.rst = 1; d.rw = 1;
    cyc(d, E(32'hBFC00000, 1, 0, 0, 0, 0, 0));
    d = nop(); d.rw = 1;
    cyc(d, R(E(32'hBFC00000, 1, 0, 1, 0, 0, 0), 0));
    // JR to FFFFFFFC, PC+4 wraps to 0 without halting
    d = nop(); d.jr = 1; d.jrt = 32'hFFFFFFFC;
    cyc(d, R(E(32'hBFC00004, 1, 0, 0, 0, 0, 0), 1));
    d = nop();
    cyc(d, R(E(32'hBFC00008, 1, 1, 0, 0, 0, 0), 2));
    cyc(d, R(E(32'hFFFFFFFC, 1, 0, 0, 0, 0, 0), 3));
    d = nop(); d.ld = 1;
    cyc(d, R(E(32'h00000000, 1, 0, 0, 1, 0, 0), 4));
    d = nop();
    cyc(d, E(32'h00000004, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4 && sb.size() > 0; i++)
      @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
